// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipelined datapath stage registers.
package pipe_pkg;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_e;

  localparam int PIPE_DEFAULT_WIDTH = 16;

endpackage

// File: rtl/pipe_stage_reg_sat_counter.sv
// Saturating up-counter with synchronous active-high clear.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst)
      r_cnt <= '0;
    else if (i_inc && (r_cnt != {CNT_W{1'b1}}))
      r_cnt <= r_cnt + CNT_ONE;
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with a 2-entry skid buffer, valid/ready handshake and flush.
// Optional stall counter enabled by defining PIPE_STAGE_STALL_CNT_EN.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int               WIDTH     = PIPE_DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter int               CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
`ifdef PIPE_STAGE_STALL_CNT_EN
  ,
  output logic [CNT_W-1:0] stall_cnt
`endif
);

  occ_e             r_occ;
  occ_e             w_occ_nxt;
  logic [WIDTH-1:0] r_data;
  logic [WIDTH-1:0] r_skid;
  logic             w_valid;
  logic             w_skid_valid;
  logic             w_acc;
  logic             w_pop;
  logic             w_ld_main;
  logic             w_main_from_skid;
  logic             w_ld_skid;

  assign w_valid      = (r_occ != OCC_EMPTY);
  assign w_skid_valid = (r_occ == OCC_FULL);

  // in_ready looks only at state (and rst), so it never combinationally follows out_ready.
  assign in_ready  = !w_skid_valid && !rst;
  assign out_valid = w_valid;
  assign out_data  = r_data;

  assign w_acc = in_valid && in_ready;
  assign w_pop = w_valid && out_ready;

  always_comb begin
    w_occ_nxt        = r_occ;
    w_ld_main        = 1'b0;
    w_main_from_skid = 1'b0;
    w_ld_skid        = 1'b0;
    case (r_occ)
      OCC_EMPTY: begin
        if (w_acc) begin
          w_occ_nxt = OCC_ONE;
          w_ld_main = 1'b1;
        end
      end
      OCC_ONE: begin
        if (w_pop && !w_acc) begin
          w_occ_nxt = OCC_EMPTY;
        end else if (w_pop && w_acc) begin
          w_ld_main = 1'b1;
        end else if (w_acc) begin
          w_occ_nxt = OCC_FULL;
          w_ld_skid = 1'b1;
        end
      end
      OCC_FULL: begin
        // Skid drains into main; the skid entry is never bypassed.
        if (w_pop) begin
          w_occ_nxt        = OCC_ONE;
          w_ld_main        = 1'b1;
          w_main_from_skid = 1'b1;
        end
      end
      default: w_occ_nxt = OCC_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_occ  <= OCC_EMPTY;
      r_data <= RESET_VAL;
      r_skid <= RESET_VAL;
    end else begin
      r_occ <= w_occ_nxt;
      if (w_ld_main)
        r_data <= w_main_from_skid ? r_skid : in_data;
      if (w_ld_skid)
        r_skid <= in_data;
    end
  end

`ifdef PIPE_STAGE_STALL_CNT_EN
  logic w_stall;

  assign w_stall = w_valid && !out_ready;

  sat_counter #(
    .CNT_W(CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .i_inc (w_stall),
    .o_cnt (stall_cnt)
  );
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed + randomized bench for pipe_stage_reg against a queue-based reference model.
module tb_pipe_stage_reg;

  localparam int            W  = 16;
  localparam logic [W-1:0]  RV = 16'h5A5A;
  localparam int            CW = 4;
  localparam int            CMAX = (1 << CW) - 1;

  logic         clk = 1'b0;
  logic         rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [W-1:0] in_data, out_data;
`ifdef PIPE_STAGE_STALL_CNT_EN
  logic [CW-1:0] stall_cnt;
`endif

  pipe_stage_reg #(
    .WIDTH     (W),
    .RESET_VAL (RV),
    .CNT_W     (CW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
`ifdef PIPE_STAGE_STALL_CNT_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int           checks = 0;
  int           errors = 0;
  logic [W-1:0] q[$];
  logic [W-1:0] m_last = RV;
  int           m_cnt  = 0;
  bit           m_ok   = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, check outputs against the model, advance the model.
  task automatic step(input bit r, input bit f, input bit iv, input logic [W-1:0] d, input bit ordy);
    bit           acc, pop;
    logic [W-1:0] e_data;
    rst = r; flush = f; in_valid = iv; in_data = d; out_ready = ordy;
    #1;
    if (m_ok) begin
      e_data = (q.size() > 0) ? q[0] : m_last;
      chk("out_valid", {31'd0, out_valid}, {31'd0, q.size() > 0});
      chk("out_data",  {16'd0, out_data},  {16'd0, e_data});
      chk("in_ready",  {31'd0, in_ready},  {31'd0, (q.size() < 2) && !r});
`ifdef PIPE_STAGE_STALL_CNT_EN
      chk("stall_cnt", {28'd0, stall_cnt}, m_cnt);
`endif
    end
    acc = iv && (q.size() < 2) && !r;
    pop = (q.size() > 0) && ordy;
    @(posedge clk);
    if (r) m_cnt = 0;
    else if ((q.size() > 0) && !ordy && (m_cnt < CMAX)) m_cnt++;
    if (r) m_ok = 1'b1;
    if (r || f) begin
      q.delete();
      m_last = RV;
    end else begin
      if (pop) m_last = q.pop_front();
      if (acc) q.push_back(d);
    end
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    @(negedge clk);

    // Reset held two cycles, then released
    step(1, 0, 0, 16'h0, 0);
    step(1, 0, 0, 16'h0, 0);
    chk("rst_out_data", {16'd0, out_data}, {16'd0, RV});
    step(0, 0, 0, 16'h0, 1);

    // Back-to-back streaming
    for (int i = 1; i <= 8; i++) step(0, 0, 1, W'(i), 1);
    step(0, 0, 0, 16'h0, 1);
    step(0, 0, 0, 16'h0, 1);

    // Backpressure fills main + skid, third word held upstream
    step(0, 0, 1, 16'h00A1, 0);
    step(0, 0, 1, 16'h00A2, 0);
    step(0, 0, 1, 16'h00A3, 0);
    step(0, 0, 1, 16'h00A3, 0);
    step(0, 0, 1, 16'h00A3, 1);
    step(0, 0, 1, 16'h00A3, 1);
    step(0, 0, 0, 16'h0, 1);
    step(0, 0, 0, 16'h0, 1);
    step(0, 0, 0, 16'h0, 1);

    // Flush while full, with a word offered in the flush cycle
    step(0, 0, 1, 16'h00B1, 0);
    step(0, 0, 1, 16'h00B2, 0);
    step(0, 1, 1, 16'h0BAD, 1);
    step(0, 0, 0, 16'h0, 1);
    step(0, 0, 0, 16'h0, 1);

    // Reset mid-stream with pop and accept in the same cycle
    step(0, 0, 1, 16'h00C1, 1);
    step(0, 0, 1, 16'h00C2, 0);
    step(1, 0, 1, 16'h00C3, 1);
    chk("rst_mid_data", {16'd0, out_data}, {16'd0, RV});
    step(0, 0, 0, 16'h0, 1);

`ifdef PIPE_STAGE_STALL_CNT_EN
    // Stall counter saturation, unaffected by flush
    step(0, 0, 1, 16'h00D1, 0);
    for (int i = 0; i < 20; i++) step(0, 0, 0, 16'h0, 0);
    chk("stall_sat", {28'd0, stall_cnt}, CMAX);
    step(0, 1, 0, 16'h0, 0);
    step(0, 0, 0, 16'h0, 0);
    chk("stall_after_flush", {28'd0, stall_cnt}, CMAX);
    step(1, 0, 0, 16'h0, 0);
    step(0, 0, 0, 16'h0, 1);
`endif

    // Randomized traffic with occasional flush and reset
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 59) == 0),
           ($urandom_range(0, 19) == 0),
           1'($urandom_range(0, 1)),
           W'($urandom),
           ($urandom_range(0, 9) < 7));
    end
    step(0, 0, 0, 16'h0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
